fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100, SHALL be the PC loaded on a misaligned redirect.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port Areset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port imem_req  output  1  SHALL be the instruction memory read request.
REQ-006 Port imem_addr  output  32  SHALL be the fetch address, equal to the current PC.
REQ-007 Port imem_ready  input  1  SHALL mean imem_rdata is valid this cycle; it completes the request.
REQ-008 Port imem_rdata  input  32  SHALL be the instruction word returned by memory.
REQ-009 Port instr_valid  output  1  SHALL mean instr and instr_pc hold a fetched instruction.
REQ-010 Port instr  output  32  SHALL be the held instruction word.
REQ-011 Port instr_pc  output  32  SHALL be the address of the held instruction.
REQ-012 Port id_ready  input  1  SHALL mean the decode/execute stage accepts the held instruction this cycle.
REQ-013 Port redirect_valid  input  1  SHALL request a PC redirect (taken branch/jump).
REQ-014 Port redirect_target  input  32  SHALL be the redirect destination (PC+ImmExt, computed outside).
REQ-015 Port halt_req  input  1  SHALL request the sequencer to stop fetching.
REQ-016 Port resume  input  1  SHALL restart fetching from the held PC when halted.
REQ-017 Port trap_pulse  output  1  SHALL pulse one cycle when a misaligned redirect is taken.
REQ-018 Port halted  output  1  SHALL be high while in HALT.
REQ-019 Port instret  output  32  SHALL count accepted instructions.

Function
REQ-020 FSM states SHALL be FETCH, HOLD, HALT; reset state FETCH.
REQ-021 In FETCH, imem_req SHALL be 1; imem_addr SHALL stay stable until imem_ready.
REQ-022 FETCH with imem_ready SHALL capture imem_rdata/PC into instr/instr_pc and enter HOLD next cycle.
REQ-023 In HOLD, instr_valid SHALL be 1 and imem_req 0; instr/instr_pc SHALL stay stable until id_ready.
REQ-024 HOLD with id_ready SHALL increment instret (mod 2^32 wrap) and update PC, all in that same edge.
REQ-025 PC update on acceptance SHALL be redirect_target if redirect_valid, else PC+4 (mod 2^32).
REQ-026 A redirect with redirect_target[1:0] != 0 SHALL load TRAP_VECTOR instead and assert trap_pulse for exactly the next cycle.
REQ-027 redirect_valid SHALL be ignored unless instr_valid and id_ready are both 1.
REQ-028 After acceptance the FSM SHALL go to FETCH, or to HALT if halt_req is 1 that cycle.
REQ-029 halt_req in FETCH SHALL be deferred: the outstanding request completes, then HOLD, then HALT on acceptance.
REQ-030 In HALT, imem_req and instr_valid SHALL be 0 and PC SHALL hold; resume SHALL enter FETCH next cycle.
REQ-031 halt_req and resume both high in HALT SHALL keep HALT (halt wins).
REQ-032 Latency: first imem_req SHALL be the first cycle after Areset deasserts; back-to-back zero-wait fetch throughput SHALL be one instruction per 2 cycles.

Reset
REQ-033 Areset low SHALL immediately set PC=RESET_VECTOR, state=FETCH, instr=0, instr_pc=0, instret=0, trap_pulse=0.
REQ-034 Reset mid-request SHALL abandon the request; a stale imem_ready after reset SHALL be captured only against RESET_VECTOR.

Structure
REQ-035 A shared package SHALL hold the state encoding (FETCH=2'b00, HOLD=2'b01, HALT=2'b10) and the constant PC_STEP=4.
REQ-036 One sub-module SHALL be natural: the existing program counter register, instantiated with the next-PC mux kept in fetch_sequencer.

Verification
REQ-037 Reset then imem_ready=1 every FETCH, id_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; instret=3 after three accepts.
REQ-038 Accept at PC 0x8 with redirect_valid=1, target 0x40 -> next imem_addr=0x40, instret increments once.
REQ-039 Redirect target 0x42 -> next imem_addr=0x100, trap_pulse high exactly one cycle.
REQ-040 imem_ready held 0 for 5 cycles -> imem_addr constant, instr_valid 0; id_ready held 0 in HOLD -> instr stable.
REQ-041 halt_req during FETCH at PC 0xC -> HOLD, then HALT after accept with PC=0x10; resume -> imem_addr=0x10.
REQ-042 instret preset near 0xFFFF_FFFF via two accepts across the wrap -> reads 0x0000_0000; Areset mid-FETCH -> PC=0x0 immediately.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//   Shared definitions for the fetch sequencer: FSM state encoding, the
//   sequential PC increment, and a helper for word-alignment checks.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    HALT  = 2'b10
  } fsm_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Only the two low address bits decide word alignment.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc.sv
// fetch_sequencer_pc
//   Program counter register. Loads pc_d_i when pc_we_i is high; the
//   next-PC selection lives in the parent.
// Ports:
//   clk      - clock, rising edge
//   Areset   - asynchronous active-low reset, loads RESET_VECTOR
//   pc_we_i  - write enable
//   pc_d_i   - next PC value
//   pc_o     - current PC
module fetch_sequencer_pc #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        Areset,
  input  logic        pc_we_i,
  input  logic [31:0] pc_d_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;

  always_ff @(posedge clk or negedge Areset) begin
    if (!Areset) begin
      pc_q <= RESET_VECTOR;
    end else if (pc_we_i) begin
      pc_q <= pc_d_i;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction fetch sequencer: requests the word at PC, holds the returned
//   instruction until decode accepts it, then advances PC (sequential,
//   redirect, or trap on a misaligned redirect). Supports halt/resume and
//   counts retired (accepted) instructions.
// Ports:
//   clk, Areset                    - clock / async active-low reset
//   imem_req, imem_addr            - fetch request and address (= PC)
//   imem_ready, imem_rdata         - memory response
//   instr_valid, instr, instr_pc   - held instruction towards decode
//   id_ready                       - decode accepts held instruction
//   redirect_valid/_target         - branch/jump redirect on acceptance
//   halt_req, resume, halted       - halt control and status
//   trap_pulse                     - one-cycle pulse on misaligned redirect
//   instret                        - accepted instruction count
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        Areset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic        trap_pulse,
  output logic        halted,
  output logic [31:0] instret
);

  fsm_state_e  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] instret_q, instret_d;
  logic        trap_q, trap_d;
  logic        halt_pend_q, halt_pend_d;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_we;

  fetch_sequencer_pc #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc (
    .clk    (clk),
    .Areset (Areset),
    .pc_we_i(pc_we),
    .pc_d_i (pc_next),
    .pc_o   (pc)
  );

  always_ff @(posedge clk or negedge Areset) begin
    if (!Areset) begin
      state_q     <= FETCH;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      instret_q   <= '0;
      trap_q      <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      instret_q   <= instret_d;
      trap_q      <= trap_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    instret_d   = instret_q;
    trap_d      = 1'b0;
    halt_pend_d = halt_pend_q;
    pc_we       = 1'b0;
    pc_next     = pc + PC_STEP;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        // A halt seen mid-fetch is remembered and applied at acceptance.
        if (halt_req) halt_pend_d = 1'b1;
        if (imem_ready) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (id_ready) begin
          instret_d = instret_q + 32'd1;
          pc_we     = 1'b1;
          if (redirect_valid) begin
            if (is_misaligned(redirect_target[1:0])) begin
              pc_next = TRAP_VECTOR;
              trap_d  = 1'b1;
            end else begin
              pc_next = redirect_target;
            end
          end
          if (halt_req || halt_pend_q) begin
            state_d     = HALT;
            halt_pend_d = 1'b0;
          end else begin
            state_d = FETCH;
          end
        end else if (halt_req) begin
          halt_pend_d = 1'b1;
        end
      end
      HALT: begin
        halted = 1'b1;
        if (resume && !halt_req) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign imem_addr  = pc;
  assign instr      = instr_q;
  assign instr_pc   = instr_pc_q;
  assign instret    = instret_q;
  assign trap_pulse = trap_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        Areset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        id_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic        trap_pulse;
  logic        halted;
  logic [31:0] instret;

  int errors = 0;
  int checks = 0;

  fetch_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100)
  ) dut (
    .clk            (clk),
    .Areset         (Areset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halt_req       (halt_req),
    .resume         (resume),
    .trap_pulse     (trap_pulse),
    .halted         (halted),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rdy;
    logic [31:0] rdata;
    logic        idr;
    logic        rv;
    logic [31:0] rt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_trap;
    logic [31:0] e_instret;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic rdy, input logic [31:0] rdata,
                              input logic idr, input logic rv, input logic [31:0] rt,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_instr,
                              input logic [31:0] e_ipc, input logic e_trap,
                              input logic [31:0] e_instret);
    vec_t v;
    v.rdy = rdy; v.rdata = rdata; v.idr = idr; v.rv = rv; v.rt = rt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_trap = e_trap;
    v.e_instret = e_instret;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic [31:0] rd, input logic idr,
                       input logic rv, input logic [31:0] rt,
                       input logic hr, input logic rs);
    imem_ready      = rdy;
    imem_rdata      = rd;
    id_ready        = idr;
    redirect_valid  = rv;
    redirect_target = rt;
    halt_req        = hr;
    resume          = rs;
  endtask

  // One fetch (zero wait) plus one acceptance, leaving the DUT in FETCH.
  task automatic accept_one(input logic [31:0] rd);
    drive(1'b1, rd, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    // Rows: inputs for this cycle, expected outputs before this cycle's edge.
    tbl[0]  = mk(1, 32'hA000_0000, 0, 0, '0,            1, 32'h000, 0, 32'h0,          32'h000, 0, 0);
    tbl[1]  = mk(0, 32'hDEAD_BEEF, 1, 0, '0,            0, 32'h000, 1, 32'hA000_0000, 32'h000, 0, 0);
    tbl[2]  = mk(1, 32'hA000_0004, 0, 0, '0,            1, 32'h004, 0, 32'hA000_0000, 32'h000, 0, 1);
    tbl[3]  = mk(0, 32'hDEAD_BEEF, 1, 0, '0,            0, 32'h004, 1, 32'hA000_0004, 32'h004, 0, 1);
    tbl[4]  = mk(1, 32'hA000_0008, 0, 0, '0,            1, 32'h008, 0, 32'hA000_0004, 32'h004, 0, 2);
    tbl[5]  = mk(0, 32'hDEAD_BEEF, 1, 1, 32'h40,        0, 32'h008, 1, 32'hA000_0008, 32'h008, 0, 2);
    tbl[6]  = mk(1, 32'hA000_0040, 0, 0, '0,            1, 32'h040, 0, 32'hA000_0008, 32'h008, 0, 3);
    tbl[7]  = mk(0, 32'hDEAD_BEEF, 1, 1, 32'h42,        0, 32'h040, 1, 32'hA000_0040, 32'h040, 0, 3);
    tbl[8]  = mk(0, 32'hDEAD_BEEF, 0, 1, 32'h200,       1, 32'h100, 0, 32'hA000_0040, 32'h040, 1, 4);
    tbl[9]  = mk(0, 32'hDEAD_BEEF, 1, 1, 32'h200,       1, 32'h100, 0, 32'hA000_0040, 32'h040, 0, 4);
    tbl[10] = mk(0, 32'hDEAD_BEEF, 1, 1, 32'h200,       1, 32'h100, 0, 32'hA000_0040, 32'h040, 0, 4);
    tbl[11] = mk(0, 32'hDEAD_BEEF, 0, 0, '0,            1, 32'h100, 0, 32'hA000_0040, 32'h040, 0, 4);
    tbl[12] = mk(0, 32'hDEAD_BEEF, 0, 0, '0,            1, 32'h100, 0, 32'hA000_0040, 32'h040, 0, 4);
    tbl[13] = mk(1, 32'hA000_0100, 0, 0, '0,            1, 32'h100, 0, 32'hA000_0040, 32'h040, 0, 4);
    tbl[14] = mk(1, 32'h0000_0BAD, 0, 1, 32'h300,       0, 32'h100, 1, 32'hA000_0100, 32'h100, 0, 4);
    tbl[15] = mk(1, 32'h0000_0BAD, 0, 1, 32'h300,       0, 32'h100, 1, 32'hA000_0100, 32'h100, 0, 4);
    tbl[16] = mk(0, 32'h0000_0BAD, 0, 0, '0,            0, 32'h100, 1, 32'hA000_0100, 32'h100, 0, 4);
    tbl[17] = mk(0, 32'h0000_0BAD, 1, 0, '0,            0, 32'h100, 1, 32'hA000_0100, 32'h100, 0, 4);
    tbl[18] = mk(0, 32'hDEAD_BEEF, 0, 0, '0,            1, 32'h104, 0, 32'hA000_0100, 32'h100, 0, 5);

    // Reset state while Areset is held low.
    #1 Areset = 1'b0;
    @(negedge clk);
    #1;
    chk("rst imem_req",    {31'b0, imem_req},    32'd1);
    chk("rst imem_addr",   imem_addr,            32'h0);
    chk("rst instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst instr",       instr,                32'h0);
    chk("rst instr_pc",    instr_pc,             32'h0);
    chk("rst instret",     instret,              32'h0);
    chk("rst trap_pulse",  {31'b0, trap_pulse},  32'd0);
    chk("rst halted",      {31'b0, halted},      32'd0);
    @(negedge clk);
    Areset = 1'b1;

    for (int unsigned i = 0; i < 19; i++) begin
      drive(tbl[i].rdy, tbl[i].rdata, tbl[i].idr, tbl[i].rv, tbl[i].rt, 1'b0, 1'b0);
      #1;
      chk($sformatf("row%0d imem_req", i),    {31'b0, imem_req},    {31'b0, tbl[i].e_req});
      chk($sformatf("row%0d imem_addr", i),   imem_addr,            tbl[i].e_addr);
      chk($sformatf("row%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("row%0d instr", i),       instr,                tbl[i].e_instr);
      chk($sformatf("row%0d instr_pc", i),    instr_pc,             tbl[i].e_ipc);
      chk($sformatf("row%0d trap_pulse", i),  {31'b0, trap_pulse},  {31'b0, tbl[i].e_trap});
      chk($sformatf("row%0d halted", i),      {31'b0, halted},      32'd0);
      chk($sformatf("row%0d instret", i),     instret,              tbl[i].e_instret);
      @(negedge clk);
    end

    // Halt deferred from FETCH at 0xC, then resume from 0x10.
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    Areset = 1'b0;
    @(negedge clk);
    Areset = 1'b1;
    accept_one(32'hC000_0000);
    accept_one(32'hC000_0004);
    accept_one(32'hC000_0008);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    chk("halt fetch addr", imem_addr, 32'h0C);
    chk("halt fetch req",  {31'b0, imem_req}, 32'd1);
    @(negedge clk);
    drive(1'b1, 32'hC000_000C, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("halt deferred req", {31'b0, imem_req}, 32'd1);
    chk("halt deferred halted", {31'b0, halted}, 32'd0);
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("halt hold valid", {31'b0, instr_valid}, 32'd1);
    chk("halt hold instr", instr, 32'hC000_000C);
    chk("halt hold pc",    instr_pc, 32'h0C);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    #1;
    chk("halt state halted",  {31'b0, halted},      32'd1);
    chk("halt state req",     {31'b0, imem_req},    32'd0);
    chk("halt state valid",   {31'b0, instr_valid}, 32'd0);
    chk("halt state pc",      imem_addr,            32'h10);
    chk("halt state instret", instret,              32'd4);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    #1;
    chk("halt wins halted", {31'b0, halted}, 32'd1);
    chk("halt wins pc",     imem_addr,       32'h10);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("resume halted", {31'b0, halted},   32'd0);
    chk("resume req",    {31'b0, imem_req}, 32'd1);
    chk("resume addr",   imem_addr,         32'h10);

    // instret wrap: preset the counter, then two acceptances.
    force dut.instret_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.instret_q;
    #1;
    chk("wrap preset", instret, 32'hFFFF_FFFE);
    accept_one(32'hE000_0010);
    #1;
    chk("wrap first", instret, 32'hFFFF_FFFF);
    accept_one(32'hE000_0014);
    #1;
    chk("wrap second", instret, 32'h0000_0000);
    chk("wrap addr",   imem_addr, 32'h18);

    // Reset mid-FETCH takes effect without a clock edge.
    Areset = 1'b0;
    #1;
    chk("async rst addr",    imem_addr, 32'h0);
    chk("async rst instr",   instr,     32'h0);
    chk("async rst ipc",     instr_pc,  32'h0);
    chk("async rst instret", instret,   32'h0);
    chk("async rst req",     {31'b0, imem_req}, 32'd1);
    @(negedge clk);
    // Response arriving right as reset lifts binds to the reset vector.
    drive(1'b1, 32'h5555_AAAA, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    Areset = 1'b1;
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("stale valid", {31'b0, instr_valid}, 32'd1);
    chk("stale instr", instr,    32'h5555_AAAA);
    chk("stale ipc",   instr_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
